// File: rtl/irrigation_mode_controller_if.sv
// Sensor inputs and mode/status outputs of the irrigation mode controller.
// fault_o exists only when IRRIGATION_FAULT_LATCH_EN is defined.
interface irrigation_mode_controller_if;
    logic enable_i;
    logic humidity_low_i;
    logic humidity_critical_i;
    logic temperature_high_i;
    logic water_low_i;
    logic sprinkler_status_o;
    logic drip_status_o;
    logic valve_open_o;
    logic cooldown_o;
`ifdef IRRIGATION_FAULT_LATCH_EN
    logic fault_o;
`endif

`ifdef IRRIGATION_FAULT_LATCH_EN
    modport slave (
        input  enable_i, humidity_low_i, humidity_critical_i, temperature_high_i, water_low_i,
        output sprinkler_status_o, drip_status_o, valve_open_o, cooldown_o, fault_o
    );
    modport master (
        output enable_i, humidity_low_i, humidity_critical_i, temperature_high_i, water_low_i,
        input  sprinkler_status_o, drip_status_o, valve_open_o, cooldown_o, fault_o
    );
`else
    modport slave (
        input  enable_i, humidity_low_i, humidity_critical_i, temperature_high_i, water_low_i,
        output sprinkler_status_o, drip_status_o, valve_open_o, cooldown_o
    );
    modport master (
        output enable_i, humidity_low_i, humidity_critical_i, temperature_high_i, water_low_i,
        input  sprinkler_status_o, drip_status_o, valve_open_o, cooldown_o
    );
`endif
endinterface

// File: rtl/irrigation_mode_controller.sv
// Irrigation mode FSM: mutually exclusive sprinkler/drip, minimum on-time, cooldown, low-tank abort.
// Optional sticky low-tank fault latch enabled by defining IRRIGATION_FAULT_LATCH_EN.
module irrigation_mode_controller #(
    parameter int unsigned MIN_ON_CYCLES   = 8,
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    irrigation_mode_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPRINKLER = 2'd1,
        DRIP      = 2'd2,
        COOLDOWN  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] MIN_ON_LOAD   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             sprinkler_q, sprinkler_d;
    logic             drip_q, drip_d;
    logic             valve_q, valve_d;
    logic             cooldown_q, cooldown_d;

    logic go;
    logic hot;
    logic abort;
    logic timer_done;
    logic arm_ok;

`ifdef IRRIGATION_FAULT_LATCH_EN
    logic fault_q, fault_d;
`endif

    assign go         = bus.enable_i & bus.humidity_low_i & ~bus.water_low_i;
    assign hot        = bus.humidity_critical_i | bus.temperature_high_i;
    assign abort      = ~bus.enable_i | bus.water_low_i;
    assign timer_done = (timer_q == '0);

`ifdef IRRIGATION_FAULT_LATCH_EN
    assign arm_ok = ~fault_q;

    // Disabling the system clears the latch even if a low-tank abort happens on the same edge.
    always_comb begin
        fault_d = fault_q;
        if (!bus.enable_i) begin
            fault_d = 1'b0;
        end else if (((state_q == SPRINKLER) || (state_q == DRIP)) && bus.water_low_i) begin
            fault_d = 1'b1;
        end
    end
`else
    assign arm_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_done ? '0 : (timer_q - 1'b1);

        unique case (state_q)
            IDLE: begin
                if (go && arm_ok) begin
                    state_d = hot ? SPRINKLER : DRIP;
                    timer_d = MIN_ON_LOAD;
                end
            end
            SPRINKLER: begin
                if (abort || (timer_done && !bus.humidity_low_i)) begin
                    state_d = COOLDOWN;
                    timer_d = COOLDOWN_LOAD;
                end
            end
            DRIP: begin
                // Abort outranks both the timed exit and the upgrade to sprinkler.
                if (abort || (timer_done && !bus.humidity_low_i)) begin
                    state_d = COOLDOWN;
                    timer_d = COOLDOWN_LOAD;
                end else if (timer_done && hot) begin
                    state_d = SPRINKLER;
                    timer_d = MIN_ON_LOAD;
                end
            end
            COOLDOWN: begin
                if (timer_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        sprinkler_d = (state_d == SPRINKLER);
        drip_d      = (state_d == DRIP);
        valve_d     = (state_d == SPRINKLER) || (state_d == DRIP);
        cooldown_d  = (state_d == COOLDOWN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            sprinkler_q <= 1'b0;
            drip_q      <= 1'b0;
            valve_q     <= 1'b0;
            cooldown_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sprinkler_q <= sprinkler_d;
            drip_q      <= drip_d;
            valve_q     <= valve_d;
            cooldown_q  <= cooldown_d;
        end
    end

`ifdef IRRIGATION_FAULT_LATCH_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fault_o = fault_q;
`endif

    assign bus.sprinkler_status_o = sprinkler_q;
    assign bus.drip_status_o      = drip_q;
    assign bus.valve_open_o       = valve_q;
    assign bus.cooldown_o         = cooldown_q;

endmodule

// File: tb/tb_irrigation_mode_controller.sv
// Scoreboard bench for irrigation_mode_controller (MIN_ON=8, COOLDOWN=4), directed vectors.
// Expectations for fault_o follow IRRIGATION_FAULT_LATCH_EN when it is defined.
module tb_irrigation_mode_controller;

`ifdef IRRIGATION_FAULT_LATCH_EN
    localparam bit FLT = 1'b1;
`else
    localparam bit FLT = 1'b0;
`endif

    typedef struct {
        logic [4:0] v;
        string      nm;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    irrigation_mode_controller_if bus ();

    irrigation_mode_controller #(
        .MIN_ON_CYCLES   (8),
        .COOLDOWN_CYCLES (4),
        .CNT_W           (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic en, input logic hl, input logic hc,
                        input logic th, input logic wl, input logic es, input logic ed,
                        input logic ecd, input logic ef, input string nm);
        exp_t e;
        @(negedge clk);
        rst                     = r;
        bus.enable_i            = en;
        bus.humidity_low_i      = hl;
        bus.humidity_critical_i = hc;
        bus.temperature_high_i  = th;
        bus.water_low_i         = wl;
        e.v  = {es, ed, es | ed, ecd, ef & FLT};
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic run(input int n, input logic r, input logic en, input logic hl, input logic hc,
                       input logic th, input logic wl, input logic es, input logic ed,
                       input logic ecd, input logic ef, input string nm);
        for (int i = 0; i < n; i++) begin
            step(r, en, hl, hc, th, wl, es, ed, ecd, ef, nm);
        end
    endtask

    // Monitor: outputs are registered, so one queued expectation is due after every edge.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
`ifdef IRRIGATION_FAULT_LATCH_EN
                act = {bus.sprinkler_status_o, bus.drip_status_o, bus.valve_open_o,
                       bus.cooldown_o, bus.fault_o};
`else
                act = {bus.sprinkler_status_o, bus.drip_status_o, bus.valve_open_o,
                       bus.cooldown_o, 1'b0};
`endif
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: got {spr,drip,valve,cool,fault}=%b expected %b at %0t",
                             e.nm, act, e.v, $time);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst                     = 1'b1;
        bus.enable_i            = 1'b0;
        bus.humidity_low_i      = 1'b0;
        bus.humidity_critical_i = 1'b0;
        bus.temperature_high_i  = 1'b0;
        bus.water_low_i         = 1'b0;

        // Reset, then enabled with no demand
        run(2,  1, 0, 0, 0, 0, 0,  0, 0, 0, 0, "reset");
        run(10, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, "idle");

        // Drip session, humidity drops early but minimum on-time holds
        run(3,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "drip_on");
        run(5,  0, 1, 0, 0, 0, 0,  0, 1, 0, 0, "drip_min");
        run(4,  0, 1, 0, 0, 0, 0,  0, 0, 1, 0, "drip_cool");
        run(2,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, "drip_idle");

        // Upgrade drip to sprinkler with no gap
        run(1,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "upg_drip");
        run(7,  0, 1, 1, 0, 1, 0,  0, 1, 0, 0, "upg_drip_hot");
        run(10, 0, 1, 1, 0, 1, 0,  1, 0, 0, 0, "upg_spr");
        run(4,  0, 1, 0, 0, 1, 0,  0, 0, 1, 0, "upg_cool");
        run(1,  0, 1, 0, 0, 1, 0,  0, 0, 0, 0, "upg_idle");

        // Low-tank abort in sprinkler, re-arm behaviour depends on fault latch
        run(2,  0, 1, 1, 1, 0, 0,  1, 0, 0, 0, "abt_spr");
        run(4,  0, 1, 1, 1, 0, 1,  0, 0, 1, 1, "abt_cool");
        run(2,  0, 1, 1, 1, 0, 1,  0, 0, 0, 1, "abt_wait");
        run(1,  0, 1, 1, 1, 0, 0,  !FLT, 0, 0, 1, "abt_rearm");
        run(1,  0, 0, 1, 1, 0, 0,  0, 0, !FLT, 0, "abt_off");
        run(3,  0, 0, 1, 1, 0, 0,  0, 0, !FLT, 0, "abt_off_cd");
        run(1,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0, "abt_off_idle");
        run(1,  0, 1, 1, 1, 0, 0,  1, 0, 0, 0, "resume_spr");
        run(1,  0, 0, 1, 1, 0, 0,  0, 0, 1, 0, "resume_off");
        run(3,  0, 0, 1, 1, 0, 0,  0, 0, 1, 0, "resume_off_cd");
        run(1,  0, 0, 1, 1, 0, 0,  0, 0, 0, 0, "resume_idle");

        // Reset mid-drip (timer=5), then a full-length session
        run(3,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "rst_drip");
        run(1,  1, 1, 1, 0, 0, 0,  0, 0, 0, 0, "rst_mid");
        run(1,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "rst_redrip");
        run(7,  0, 1, 0, 0, 0, 0,  0, 1, 0, 0, "rst_min");
        run(4,  0, 1, 0, 0, 0, 0,  0, 0, 1, 0, "rst_cool");
        run(1,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, "rst_idle");

        // Abort and upgrade on the same edge: abort wins
        run(1,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "race_drip");
        run(7,  0, 1, 1, 0, 0, 0,  0, 1, 0, 0, "race_hold");
        run(1,  0, 1, 1, 0, 1, 1,  0, 0, 1, 1, "abort_vs_upg");
        run(3,  0, 1, 0, 0, 0, 0,  0, 0, 1, 1, "race_cool");
        run(1,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, "end_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
